sos_out_requant: RTL and testbench

//  Output stage directly downstream of the SOS biquad section. Takes the wide fixed-point

---
 rtl/sos_out_requant_if.sv | 29 ++
 rtl/sos_out_requant.sv | 149 ++++++++++++++
 tb/tb_sos_out_requant.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sos_out_requant_if.sv
// Stream bundle for sos_out_requant: input side (Y from the SOS section) and
// output side (requantized sample). The slave modport is the requant stage's
// view; the master modport is the view of whatever sources input and sinks output.
interface sos_out_requant_if #(
  parameter int unsigned WII = 12,
  parameter int unsigned WFI = 26,
  parameter int unsigned WIQ = 3,
  parameter int unsigned WFQ = 7
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WII+WFI-1:0]     Y_in;
  logic                   ovf_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIQ+WFQ-1:0]     Q_out;
  logic                   sat_out;
  logic                   ovf_out;

  modport slave (
    input  in_valid, Y_in, ovf_in, out_ready,
    output in_ready, out_valid, Q_out, sat_out, ovf_out
  );

  modport master (
    output in_valid, Y_in, ovf_in, out_ready,
    input  in_ready, out_valid, Q_out, sat_out, ovf_out
  );
endinterface

// File: rtl/sos_out_requant.sv
// Output requantizer for an SOS biquad section: Q(WII).(WFI) -> Q(WIQ).(WFQ)
// with round-half-up and saturation, in a 2-stage valid/ready pipeline.
// A sticky flag collects section overflows and output saturations.
// Optional feature macro: SOS_REQUANT_SATCNT_EN adds a 16-bit saturating
// counter of saturated output samples (port sat_count).
module sos_out_requant #(
  parameter int unsigned WII = 12,
  parameter int unsigned WFI = 26,
  parameter int unsigned WIQ = 3,
  parameter int unsigned WFQ = 7
) (
  input  logic                    CLK,
  input  logic                    RESET,
  sos_out_requant_if.slave        bus,
  input  logic                    clr_sticky,
  output logic                    sticky_ovf
`ifdef SOS_REQUANT_SATCNT_EN
  ,
  output logic [15:0]             sat_count
`endif
);

  localparam int unsigned WY = WII + WFI;      // input width
  localparam int unsigned WQ = WIQ + WFQ;      // output width
  localparam int unsigned WR = WII + WFQ + 1;  // rounded intermediate width
  localparam int unsigned SH = WFI - WFQ;      // fractional bits dropped

  // Half an output LSB, expressed at the input scale
  localparam logic [WY:0] RndK = {{(WY-SH+1){1'b0}}, 1'b1, {(SH-1){1'b0}}};
  localparam logic [WQ-1:0] QMax = {1'b0, {(WQ-1){1'b1}}};
  localparam logic [WQ-1:0] QMin = {1'b1, {(WQ-1){1'b0}}};

  logic          w_ld1;
  logic          w_ld2;
  logic [WY:0]   w_sum;
  logic [WR-1:0] w_r;
  logic          w_unused_lsb;
  logic [WR-WQ:0] w_hi;
  logic          w_fits;
  logic [WQ-1:0] w_q;
  logic          w_sat;
  logic          w_set;

  logic          r_s1_valid;
  logic [WR-1:0] r_s1_r;
  logic          r_s1_ovf;
  logic          r_out_valid;
  logic [WQ-1:0] r_q;
  logic          r_sat;
  logic          r_ovf;
  logic          r_sticky;

  // Advance enables; in_ready depends combinationally on out_ready
  assign w_ld2        = !r_out_valid || bus.out_ready;
  assign w_ld1        = !r_s1_valid || w_ld2;
  assign bus.in_ready = w_ld1;

  // Round half up: sign-extend by one bit so adding the half-LSB cannot wrap,
  // then the arithmetic shift is just a slice of the upper bits.
  assign w_sum        = {bus.Y_in[WY-1], bus.Y_in} + RndK;
  assign w_r          = w_sum[WY:SH];
  assign w_unused_lsb = ^w_sum[SH-1:0];

  // The value fits the output when all bits above the output sign bit match it
  always_comb begin
    w_hi   = r_s1_r[WR-1:WQ-1];
    w_fits = (&w_hi) || !(|w_hi);
    w_sat  = !w_fits;
    if (w_fits) begin
      w_q = r_s1_r[WQ-1:0];
    end else if (r_s1_r[WR-1]) begin
      w_q = QMin;
    end else begin
      w_q = QMax;
    end
  end

  assign w_set = w_ld2 && r_s1_valid && (r_s1_ovf || w_sat);

  // Stage 1: register the rounded sample and its overflow flag
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_s1_valid <= 1'b0;
      r_s1_r     <= '0;
      r_s1_ovf   <= 1'b0;
    end else if (w_ld1) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_r   <= w_r;
        r_s1_ovf <= bus.ovf_in;
      end
    end
  end

  // Stage 2: register the saturated output sample
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_sat       <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_ld2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_q   <= w_q;
        r_sat <= w_sat;
        r_ovf <= r_s1_ovf;
      end
    end
  end

  // Sticky status: a new event takes priority over a clear in the same cycle
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_sticky <= 1'b0;
    end else if (w_set) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.Q_out     = r_q;
  assign bus.sat_out   = r_sat;
  assign bus.ovf_out   = r_ovf;
  assign sticky_ovf    = r_sticky;

`ifdef SOS_REQUANT_SATCNT_EN
  logic        w_inc;
  logic [15:0] r_cnt;

  assign w_inc = w_ld2 && r_s1_valid && w_sat;

  // Saturation counter: clear and increment together leave a count of one
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= '0;
    end else if (clr_sticky) begin
      r_cnt <= w_inc ? 16'd1 : 16'd0;
    end else if (w_inc && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign sat_count = r_cnt;
`endif

endmodule

// File: tb/tb_sos_out_requant.sv
// Directed bench for sos_out_requant with a scoreboard of expected outputs.
module tb_sos_out_requant;

  localparam int  SH   = 19;          // WFI - WFQ
  localparam int  QMAX = 511;
  localparam int  QMIN = -512;
  localparam longint ONE = 64'sd67108864;  // 1.0 in Q12.26

  typedef struct {
    int q;
    bit sat;
    bit ovf;
  } exp_t;

  logic CLK;
  logic RESET;
  logic clr_sticky;
  logic sticky_ovf;
`ifdef SOS_REQUANT_SATCNT_EN
  logic [15:0] sat_count;
`endif

  sos_out_requant_if bus_if ();

  sos_out_requant dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .bus        (bus_if.slave),
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf)
`ifdef SOS_REQUANT_SATCNT_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int     n_cmp = 0;
  int     n_err = 0;
  exp_t   sb[$];
  longint cur_raw;
  bit     stalled;
  int     held_q;
  bit     acc;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input longint raw, input bit ovf);
    exp_t   e;
    longint r;
    r = (raw + (64'sd1 <<< (SH - 1))) >>> SH;
    if (r > QMAX) begin
      e.q = QMAX; e.sat = 1'b1;
    end else if (r < QMIN) begin
      e.q = QMIN; e.sat = 1'b1;
    end else begin
      e.q = int'(r); e.sat = 1'b0;
    end
    e.ovf = ovf;
    return e;
  endfunction

  task automatic drive(input longint raw, input bit ovf, input bit vld);
    cur_raw        = raw;
    bus_if.Y_in    = raw[37:0];
    bus_if.ovf_in  = ovf;
    bus_if.in_valid = vld;
  endtask

  // One clock: check handshake-side expectations just before the edge, then advance.
  task automatic tick(output bit accepted);
    exp_t e;
    #1;
    if (stalled) begin
      chk("stall_valid", longint'(bus_if.out_valid), 1);
      chk("stall_q", longint'($signed(bus_if.Q_out)), longint'(held_q));
    end
    chk("in_ready", longint'(bus_if.in_ready),
        longint'(!(sb.size() == 2 && !bus_if.out_ready)));
    if (bus_if.out_valid && bus_if.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("q_out", longint'($signed(bus_if.Q_out)), longint'(e.q));
        chk("sat_out", longint'(bus_if.sat_out), longint'(e.sat));
        chk("ovf_out", longint'(bus_if.ovf_out), longint'(e.ovf));
      end
    end
    accepted = bus_if.in_valid && bus_if.in_ready;
    if (accepted) sb.push_back(model(cur_raw, bus_if.ovf_in));
    stalled = bus_if.out_valid && !bus_if.out_ready;
    held_q  = int'($signed(bus_if.Q_out));
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    bit a;
    drive(0, 1'b0, 1'b0);
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick(a);
    chk("drain_empty", longint'(sb.size()), 0);
  endtask

  task automatic clr_pulse();
    bit a;
    clr_sticky = 1'b1;
    tick(a);
    clr_sticky = 1'b0;
  endtask

  initial begin
    bit pat[4];
    int k;
    int cyc;
    longint t1[5];
    longint t2[3];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    stalled = 1'b0;
    held_q  = 0;
    RESET   = 1'b0;
    clr_sticky = 1'b0;
    bus_if.out_ready = 1'b1;
    drive(0, 1'b0, 1'b0);

    // Reset state
    #2;
    chk("rst_out_valid", longint'(bus_if.out_valid), 0);
    chk("rst_q", longint'(bus_if.Q_out), 0);
    chk("rst_sat", longint'(bus_if.sat_out), 0);
    chk("rst_ovf", longint'(bus_if.ovf_out), 0);
    chk("rst_sticky", longint'(sticky_ovf), 0);
    chk("rst_in_ready", longint'(bus_if.in_ready), 1);
    #10;
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // T1: rounding and latency
    drive(64'sd100663296, 1'b0, 1'b1);
    tick(acc);
    chk("t1_accept", longint'(acc), 1);
    drive(0, 1'b0, 1'b0);
    chk("t1_lat1", longint'(bus_if.out_valid), 0);
    tick(acc);
    chk("t1_lat2", longint'(bus_if.out_valid), 1);
    chk("t1_q192", longint'($signed(bus_if.Q_out)), 192);
    drain();
    t1 = '{64'sd262144, 64'sd262143, -64'sd262144, -64'sd262145, 64'sd100663296};
    foreach (t1[i]) begin
      drive(t1[i], 1'b0, 1'b1);
      tick(acc);
    end
    drain();
    chk("t1_sticky", longint'(sticky_ovf), 0);

    // T2: saturation, including a rounding carry past +max
    t2 = '{5 * ONE, -6 * ONE, 4 * ONE - 1};
    foreach (t2[i]) begin
      drive(t2[i], 1'b0, 1'b1);
      tick(acc);
    end
    drain();
    chk("t2_sticky_set", longint'(sticky_ovf), 1);
    clr_pulse();
    chk("t2_sticky_clr", longint'(sticky_ovf), 0);

    // T3: backpressure with out_ready pattern 1,0,0,1
    k = 1;
    cyc = 0;
    while (k <= 8 && cyc < 200) begin
      drive(longint'(k) <<< SH, 1'b0, 1'b1);
      bus_if.out_ready = pat[cyc % 4];
      tick(acc);
      if (acc) k++;
      cyc++;
    end
    chk("t3_all_sent", longint'(k), 9);
    drain();

    // T4: overflow flag travels with sample 3 only
    for (int i = 1; i <= 5; i++) begin
      drive(longint'(i) <<< SH, (i == 3), 1'b1);
      tick(acc);
    end
    drain();
    chk("t4_sticky", longint'(sticky_ovf), 1);
    clr_pulse();
    chk("t4_sticky_clr", longint'(sticky_ovf), 0);
    drive(64'sd1 <<< SH, 1'b1, 1'b1);
    tick(acc);
    drive(0, 1'b0, 1'b0);
    clr_sticky = 1'b1;
    tick(acc);
    clr_sticky = 1'b0;
    chk("t4_set_wins", longint'(sticky_ovf), 1);
    drain();

    // T5: asynchronous reset with both stages full
    bus_if.out_ready = 1'b0;
    drive(64'sd2 <<< SH, 1'b0, 1'b1);
    tick(acc);
    drive(64'sd3 <<< SH, 1'b0, 1'b1);
    tick(acc);
    drive(0, 1'b0, 1'b0);
    chk("t5_full_valid", longint'(bus_if.out_valid), 1);
    chk("t5_full_ready", longint'(bus_if.in_ready), 0);
    #2;
    RESET = 1'b0;
    #1;
    chk("t5_rst_valid", longint'(bus_if.out_valid), 0);
    chk("t5_rst_q", longint'(bus_if.Q_out), 0);
    chk("t5_rst_ready", longint'(bus_if.in_ready), 1);
    chk("t5_rst_sticky", longint'(sticky_ovf), 0);
    sb.delete();
    stalled = 1'b0;
    #3;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    bus_if.out_ready = 1'b1;
    drive(64'sd6 <<< SH, 1'b0, 1'b1);
    tick(acc);
    drive(0, 1'b0, 1'b0);
    chk("t5_lat1", longint'(bus_if.out_valid), 0);
    tick(acc);
    chk("t5_lat2", longint'(bus_if.out_valid), 1);
    drain();

`ifdef SOS_REQUANT_SATCNT_EN
    // T6: saturation counter
    for (int i = 0; i < 3; i++) begin
      drive(5 * ONE, 1'b0, 1'b1);
      tick(acc);
    end
    drain();
    chk("t6_count3", longint'(sat_count), 3);
    clr_pulse();
    chk("t6_clr", longint'(sat_count), 0);
    drive(5 * ONE, 1'b0, 1'b1);
    tick(acc);
    drive(0, 1'b0, 1'b0);
    clr_sticky = 1'b1;
    tick(acc);
    clr_sticky = 1'b0;
    chk("t6_clr_inc", longint'(sat_count), 1);
    drain();
    for (int i = 0; i < 65540; i++) begin
      drive(-6 * ONE, 1'b0, 1'b1);
      tick(acc);
    end
    drain();
    chk("t6_hold_max", longint'(sat_count), 65535);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
